// File: rtl/bus_pkg.sv
// Shared bus encodings, transfer sizes and initiator state for the bus_master slice.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package bus_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    // An access is aligned when the low address bits covered by its size are zero.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic mis;
        case (size)
            SIZE_H:  mis = addr_lo[0];
            SIZE_W:  mis = |addr_lo[1:0];
            SIZE_D:  mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Store lane replication and load lane extraction for the 64-bit bus.
// Latency: combinational. Backpressure: none.
// Driven by access size and the low three address bits.
module bus_lane_align
    import bus_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] wdata,
    input  logic [63:0] bus_rdata,
    output logic [63:0] lane_wdata,
    output logic [63:0] load_data
);

    logic [63:0] shifted;

    always_comb begin
        case (size)
            SIZE_B:  lane_wdata = {8{wdata[7:0]}};
            SIZE_H:  lane_wdata = {4{wdata[15:0]}};
            SIZE_W:  lane_wdata = {2{wdata[31:0]}};
            default: lane_wdata = wdata;
        endcase
    end

    // Byte offset times eight moves the addressed lane down to bit 0.
    always_comb begin
        shifted = bus_rdata >> {addr_lo, 3'b000};
        case (size)
            SIZE_B:  load_data = {56'd0, shifted[7:0]};
            SIZE_H:  load_data = {48'd0, shifted[15:0]};
            SIZE_W:  load_data = {32'd0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/bus_master.sv
// Single-outstanding bus initiator; optional HREADY watchdog under BUS_MASTER_TIMEOUT_EN.
// Latency: zero-wait accept -> response 3 cycles later; +1 per HREADY-low cycle; misaligned 1 cycle.
// Backpressure: req_ready low from accept until the response pulse ends; no response backpressure.
module bus_master
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [1:0]        HTRANS,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    state_t              state_q, state_d;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                accept;
    logic                timeout_hit;
    logic                bus_busy;
    logic [DATA_W-1:0]   lane_wdata;
    logic [DATA_W-1:0]   load_data;

    assign bus_busy = (state_q == ST_ADDR) || (state_q == ST_DATA);

    bus_lane_align u_align (
        .size       (size_q),
        .addr_lo    (addr_q[2:0]),
        .wdata      (wdata_q),
        .bus_rdata  (HRDATA),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stall_cnt_q <= '0;
        end else if (accept) begin
            stall_cnt_q <= '0;
        end else if (bus_busy && !HREADY) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    // Fires on the stall cycle that brings the count up to TIMEOUT.
    assign timeout_hit = bus_busy && !HREADY && (stall_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (is_misaligned(req_size, req_addr[2:0])) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d = ST_DATA;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_d = ST_RESP;
                    err_d   = HRESP;
                    rdata_d = (HRESP || wr_q) ? '0 : load_data;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q    <= 1'b0;
            size_q  <= SIZE_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Address signals stay up through the data phase so a stalled transfer sees them stable.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign HTRANS     = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR      = bus_busy ? addr_q : '0;
    assign HWRITE     = bus_busy && wr_q;
    assign HSIZE      = bus_busy ? {1'b0, size_q} : 3'b000;
    assign HWDATA     = ((state_q == ST_DATA) && wr_q) ? lane_wdata : '0;

endmodule

// File: tb/tb_bus_master.sv
// Randomized self-checking bench for bus_master against a transaction-level model.
// Define BUS_MASTER_TIMEOUT_EN to also exercise the HREADY watchdog with TIMEOUT=4.
module tb_bus_master;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam bit TE = 1'b1;
`else
    localparam int TB_TIMEOUT = 255;
    localparam bit TE = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 HCLK = ~HCLK;

    bus_master #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TB_TIMEOUT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // Store data as seen on the bus: the low (8 << size) bits repeated across all 64.
    function automatic logic [63:0] model_hwdata(input logic [1:0] sz, input logic [63:0] wd);
        logic [63:0] r;
        int n;
        n = 8 << sz;
        for (int i = 0; i < 64; i++) r[i] = wd[i % n];
        return r;
    endfunction

    function automatic logic [63:0] model_rdata(input logic [1:0] sz, input logic [63:0] a, input logic [63:0] hr);
        logic [63:0] mask;
        mask = (sz == 2'd3) ? ~64'd0 : ((64'd1 << (8 << sz)) - 64'd1);
        return (hr >> (8 * (a % 8))) & mask;
    endfunction

    // One request from an idle negedge through its response cycle; leaves the bench on the next negedge.
    task automatic do_req(input string name, input logic wr, input logic [1:0] sz, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] hr, input int astall, input int dstall,
                          input logic hresp);
        logic        mis, exp_err;
        logic [63:0] exp_rd, exp_wd;
        logic [1:0]  exp_trans;
        int          rc, data_last;
        mis       = (a % (64'd1 << sz)) != 0;
        data_last = astall + dstall + 2;
        if (mis) begin
            rc = 1; exp_err = 1'b1; exp_rd = '0;
        end else if (TE && astall >= TB_TIMEOUT) begin
            rc = TB_TIMEOUT + 1; exp_err = 1'b1; exp_rd = '0;
        end else if (TE && astall + dstall >= TB_TIMEOUT) begin
            rc = TB_TIMEOUT + 2; exp_err = 1'b1; exp_rd = '0;
        end else begin
            rc = data_last + 1; exp_err = hresp;
            exp_rd = (wr || hresp) ? 64'd0 : model_rdata(sz, a, hr);
        end
        exp_wd = wr ? model_hwdata(sz, wd) : 64'd0;

        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || HTRANS !== 2'b00) begin
            miscompares++;
            $display("FAIL %s idle: ready=%b valid=%b htrans=%b, want 1 0 00", name, req_ready, resp_valid, HTRANS);
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
        HREADY = 1'($urandom_range(0, 1)); HRESP = 1'($urandom_range(0, 1));

        for (int c = 1; c <= rc; c++) begin
            @(negedge HCLK);
            // Garbage requests while busy must be ignored.
            req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
            req_size = 2'($urandom_range(0, 3)); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
            if (c == astall + 1 || c == data_last) HREADY = 1'b1;
            else if (c < data_last) HREADY = 1'b0;
            else HREADY = 1'($urandom_range(0, 1));
            HRESP  = (c == data_last) ? hresp : 1'($urandom_range(0, 1));
            HRDATA = (c == data_last) ? hr : {$urandom, $urandom};
            #1;
            if (c < rc) begin
                exp_trans = (c <= astall + 1) ? 2'b10 : 2'b00;
                vectors++;
                if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s busy c%0d: valid=%b ready=%b, want 0 0", name, c, resp_valid, req_ready);
                end
                vectors++;
                if (HTRANS !== exp_trans) begin
                    miscompares++;
                    $display("FAIL %s htrans c%0d: got %b want %b", name, c, HTRANS, exp_trans);
                end
                vectors++;
                if (HADDR !== a || HWRITE !== wr || HSIZE !== {1'b0, sz}) begin
                    miscompares++;
                    $display("FAIL %s addrphase c%0d: haddr=%h hwrite=%b hsize=%0d, want %h %b %0d",
                             name, c, HADDR, HWRITE, HSIZE, a, wr, sz);
                end
                if (c > astall + 1) begin
                    vectors++;
                    if (HWDATA !== exp_wd) begin
                        miscompares++;
                        $display("FAIL %s hwdata c%0d: got %h want %h", name, c, HWDATA, exp_wd);
                    end
                end
            end else begin
                vectors++;
                if (resp_valid !== 1'b1 || resp_err !== exp_err || resp_rdata !== exp_rd) begin
                    miscompares++;
                    $display("FAIL %s resp c%0d: valid=%b err=%b rdata=%h, want 1 %b %h",
                             name, c, resp_valid, resp_err, resp_rdata, exp_err, exp_rd);
                end
                vectors++;
                if (HTRANS !== 2'b00 || HADDR !== 64'd0 || HWDATA !== 64'd0 || req_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s resp_bus: htrans=%b haddr=%h hwdata=%h ready=%b, want 00 0 0 0",
                             name, HTRANS, HADDR, HWDATA, req_ready);
                end
            end
        end
        @(negedge HCLK);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0 ||
            HTRANS !== 2'b00 || HADDR !== 64'd0 || HWRITE !== 1'b0 || HSIZE !== 3'd0 || HWDATA !== 64'd0) begin
            miscompares++;
            $display("FAIL reset: ready=%b valid=%b rdata=%h err=%b htrans=%b haddr=%h hwrite=%b hsize=%0d hwdata=%h, want 1 0 0 0 00 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err, HTRANS, HADDR, HWRITE, HSIZE, HWDATA);
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_directed();
        do_req("store8", 1'b1, 2'd3, 64'h1000, 64'h1122334455667788, 64'h0, 0, 0, 1'b0);
        do_req("load8", 1'b0, 2'd3, 64'h1000, 64'h0, 64'h1122334455667788, 0, 0, 1'b0);
        do_req("byte_load", 1'b0, 2'd0, 64'h1005, 64'h0, 64'h8877665544332211, 0, 0, 1'b0);
        do_req("half_misaligned", 1'b0, 2'd1, 64'h1003, 64'h0, 64'h0, 0, 0, 1'b0);
        do_req("stall_hresp", 1'b0, 2'd2, 64'h1004, 64'h0, 64'hdeadbeefcafef00d, 0, 3, 1'b1);
        do_req("word_store_stall", 1'b1, 2'd2, 64'h2008, 64'h00000000a5a5c3c3, 64'h0, 2, 1, 1'b0);
        do_req("half_store", 1'b1, 2'd1, 64'h200e, 64'hffffffffffff1234, 64'h0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_addr = 64'h2000; req_wdata = '0;
        HREADY = 1'b1; HRESP = 1'b0;
        @(negedge HCLK);
        req_valid = 1'b0;
        @(negedge HCLK);
        HREADY = 1'b0;
        #1;
        vectors++;
        if (HTRANS !== 2'b00 || HADDR !== 64'h2000 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_pre: htrans=%b haddr=%h ready=%b, want 00 2000 0", HTRANS, HADDR, req_ready);
        end
        #1 HRESETn = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || HTRANS !== 2'b00 || HADDR !== 64'd0 ||
            HWRITE !== 1'b0 || HSIZE !== 3'd0 || HWDATA !== 64'd0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: ready=%b valid=%b htrans=%b haddr=%h hsize=%0d, want 1 0 00 0 0",
                     req_ready, resp_valid, HTRANS, HADDR, HSIZE);
        end
        HREADY = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            vectors++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_mid_hold%0d: valid=%b ready=%b, want 0 1", i, resp_valid, req_ready);
            end
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
        do_req("after_reset", 1'b0, 2'd2, 64'h2004, 64'h0, 64'h1234567890abcdef, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            do_req("random", 1'($urandom_range(0, 1)), sz, a, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
        end
    endtask

`ifdef BUS_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        do_req("timeout_data", 1'b0, 2'd3, 64'h3000, 64'h0, 64'h0, 0, 20, 1'b0);
        do_req("timeout_addr", 1'b1, 2'd3, 64'h3008, 64'h55aa55aa55aa55aa, 64'h0, 20, 0, 1'b0);
        do_req("after_timeout", 1'b0, 2'd0, 64'h3001, 64'h0, 64'h000000000000ab00, 1, 1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
`ifdef BUS_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
